// File: rtl/mtm_alu_sout_deserializer.sv
// Receiver for the ALU serial response line: rebuilds 11-bit frames into bytes,
// then assembles data/error response packets and flags protocol violations.
module mtm_alu_sout_deserializer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sout,
  output logic        valid,
  output logic [31:0] c,
  output logic [3:0]  flags,
  output logic        err,
  output logic [2:0]  err_flags,
  output logic        crc_ok,
  output logic        frame_err
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state;
  logic [3:0]    bit_cnt;
  logic [8:0]    shreg;
  logic [2:0]    bc;
  logic [31:0]   cbuf;
  logic [TW-1:0] tmo_cnt;

  logic       byte_type;
  logic [7:0] byte_d;
  logic       last_bit;
  logic       data_crc_ok;
  logic       err_ctl_ok;
  logic       timeout_hit;

  // Serial CRC3, polynomial x^3+x+1, MSB first, zero initial value.
  function automatic logic [2:0] crc3(input logic [36:0] m);
    logic [2:0] r;
    logic       fb;
    r = 3'b000;
    for (int i = 36; i >= 0; i--) begin
      fb = r[2] ^ m[i];
      r  = {r[1], r[0] ^ fb, fb};
    end
    return r;
  endfunction

  // shreg holds {type, d[7:0]} once the stop bit is being sampled.
  assign byte_type   = shreg[8];
  assign byte_d      = shreg[7:0];
  assign last_bit    = (state == SHIFT) && (bit_cnt == 4'd10);
  assign data_crc_ok = (byte_d[2:0] == crc3({cbuf, 1'b0, byte_d[6:3]}));
  assign err_ctl_ok  = ~(^byte_d) && (byte_d[3:1] == byte_d[6:4]);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      bit_cnt   <= 4'd0;
      shreg     <= 9'd0;
      bc        <= 3'd0;
      cbuf      <= 32'd0;
      tmo_cnt   <= '0;
      valid     <= 1'b0;
      c         <= 32'd0;
      flags     <= 4'd0;
      err       <= 1'b0;
      err_flags <= 3'd0;
      crc_ok    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!sout) begin
            state   <= SHIFT;
            bit_cnt <= 4'd1;
            tmo_cnt <= '0;
          end else if (TIMEOUT_CYCLES != 0 && bc != 3'd0) begin
            if (timeout_hit) begin
              frame_err <= 1'b1;
              bc        <= 3'd0;
              tmo_cnt   <= '0;
            end else begin
              tmo_cnt <= tmo_cnt + TW'(1);
            end
          end
        end
        SHIFT: begin
          shreg   <= {shreg[7:0], sout};
          bit_cnt <= bit_cnt + 4'd1;
          if (last_bit) begin
            state <= IDLE;
            if (!sout) begin
              frame_err <= 1'b1;
              bc        <= 3'd0;
            end else if (!byte_type) begin
              if (bc == 3'd4) begin
                frame_err <= 1'b1;
                bc        <= 3'd0;
              end else begin
                // Bytes arrive in order, so shifting leaves byte 0 in c[31:24].
                cbuf <= {cbuf[23:0], byte_d};
                bc   <= bc + 3'd1;
              end
            end else if (!byte_d[7] && bc == 3'd4) begin
              valid  <= 1'b1;
              c      <= cbuf;
              flags  <= byte_d[6:3];
              err    <= 1'b0;
              crc_ok <= data_crc_ok;
              bc     <= 3'd0;
            end else if (byte_d[7] && bc == 3'd0) begin
              valid     <= 1'b1;
              err       <= 1'b1;
              err_flags <= byte_d[6:4];
              crc_ok    <= err_ctl_ok;
            end else begin
              frame_err <= 1'b1;
              bc        <= 3'd0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mtm_alu_sout_deserializer.sv
// Bench for mtm_alu_sout_deserializer: directed vector table, hand-built corner
// sequences and random packets checked against a byte-level reference model.
module tb_mtm_alu_sout_deserializer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sout;
  logic        valid;
  logic [31:0] c;
  logic [3:0]  flags;
  logic        err;
  logic [2:0]  err_flags;
  logic        crc_ok;
  logic        frame_err;

  mtm_alu_sout_deserializer #(.TIMEOUT_CYCLES(255)) dut (
    .clk(clk), .reset_n(reset_n), .sout(sout), .valid(valid), .c(c),
    .flags(flags), .err(err), .err_flags(err_flags), .crc_ok(crc_ok),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_valid = 0;
  int n_fe = 0;
  int n_both = 0;
  int last_valid_cyc = 0;
  int start_cyc = 0;
  bit mark_start = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      n_valid        <= n_valid + 1;
      last_valid_cyc <= cyc;
    end
    if (frame_err) n_fe <= n_fe + 1;
    if (valid && frame_err) n_both <= n_both + 1;
  end

  // Reference model state: what the output registers should hold.
  logic [31:0] m_c = 32'd0;
  logic [3:0]  m_fl = 4'd0;
  logic        m_err = 1'b0;
  logic [2:0]  m_ef = 3'd0;
  logic        m_ok = 1'b0;
  int          mbc = 0;
  logic [7:0]  mbuf [4];
  logic [8:0]  pkt_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Remainder of msg*x^3 divided by x^3+x+1, by long division.
  function automatic logic [2:0] crc_model(input logic [36:0] msg);
    logic [39:0] r;
    r = {msg, 3'b000};
    for (int i = 39; i >= 3; i--)
      if (r[i]) r[i -: 4] = r[i -: 4] ^ 4'b1011;
    return r[2:0];
  endfunction

  task automatic send_byte(input logic typ, input logic [7:0] d, input logic stop);
    logic [10:0] f;
    f = {1'b0, typ, d, stop};
    for (int i = 10; i >= 0; i--) begin
      @(negedge clk);
      sout = f[i];
      if (i == 10 && mark_start) begin
        start_cyc  = cyc + 1;
        mark_start = 1'b0;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sout = 1'b1;
    end
  endtask

  task automatic model_pkt(output int ev, output int efe);
    ev = 0;
    efe = 0;
    foreach (pkt_q[i]) begin
      logic [7:0] d;
      d = pkt_q[i][7:0];
      if (!pkt_q[i][8]) begin
        if (mbc == 4) begin efe++; mbc = 0; end
        else begin mbuf[mbc] = d; mbc++; end
      end else if (!d[7] && mbc == 4) begin
        ev++;
        m_c   = {mbuf[0], mbuf[1], mbuf[2], mbuf[3]};
        m_fl  = d[6:3];
        m_err = 1'b0;
        m_ok  = (d[2:0] == crc_model({m_c, 1'b0, d[6:3]}));
        mbc   = 0;
      end else if (d[7] && mbc == 0) begin
        ev++;
        m_err = 1'b1;
        m_ef  = d[6:4];
        m_ok  = ($countones(d) % 2 == 0) && (d[3:1] == d[6:4]);
      end else begin
        efe++;
        mbc = 0;
      end
    end
  endtask

  task automatic check_held(input string tag);
    chk({tag, " c"}, c, m_c);
    chk({tag, " flags"}, {28'd0, flags}, {28'd0, m_fl});
    chk({tag, " err"}, {31'd0, err}, {31'd0, m_err});
    chk({tag, " crc_ok"}, {31'd0, crc_ok}, {31'd0, m_ok});
    if (m_err) chk({tag, " err_flags"}, {29'd0, err_flags}, {29'd0, m_ef});
  endtask

  // Sends pkt_q (optionally with random idle gaps) and compares against the model.
  task automatic run_pkt(input string tag, input bit rgap);
    int v0, f0, ev, efe, gap;
    v0 = n_valid;
    f0 = n_fe;
    foreach (pkt_q[i]) begin
      send_byte(pkt_q[i][8], pkt_q[i][7:0], 1'b1);
      gap = 0;
      if (rgap) gap = ($urandom_range(0, 3) == 0) ? $urandom_range(150, 250) : $urandom_range(0, 2);
      idle(gap);
    end
    idle(3);
    #2;
    model_pkt(ev, efe);
    chk({tag, " valid count"}, n_valid - v0, ev);
    chk({tag, " frame_err count"}, n_fe - f0, efe);
    check_held(tag);
  endtask

  typedef struct {
    int              nb;
    logic [0:5][8:0] b;
    int              bad_stop;
    logic            exp_v;
    logic            exp_fe;
    logic [31:0]     exp_c;
    logic [3:0]      exp_fl;
    logic            exp_err;
    logic [2:0]      exp_ef;
    logic            exp_ok;
  } vec_t;

  function automatic vec_t mk(input int nb, input logic [53:0] bytes, input int bad_stop,
                              input logic ev, input logic efe, input logic [31:0] ec,
                              input logic [3:0] efl, input logic eer, input logic [2:0] eef,
                              input logic eok);
    vec_t v;
    v.nb = nb; v.b = bytes; v.bad_stop = bad_stop;
    v.exp_v = ev; v.exp_fe = efe; v.exp_c = ec; v.exp_fl = efl;
    v.exp_err = eer; v.exp_ef = eef; v.exp_ok = eok;
    return v;
  endfunction

  vec_t tv [13];

  initial begin
    logic [8:0] ctl6, ctl12;
    int v0, f0;

    ctl6  = {1'b1, 1'b0, 4'b1010, crc_model({32'h12345678, 1'b0, 4'b1010})};
    ctl12 = {1'b1, 1'b0, 4'b0110, crc_model({32'hDEADBEEF, 1'b0, 4'b0110}) ^ 3'b100};
    tv[0]  = mk(5, {9'h000, 9'h000, 9'h000, 9'h005, 9'h101, 9'h000}, -1, 1, 0, 32'h5, 4'h0, 0, 3'd0, 1);
    tv[1]  = mk(5, {9'h000, 9'h000, 9'h000, 9'h005, 9'h102, 9'h000}, -1, 1, 0, 32'h5, 4'h0, 0, 3'd0, 0);
    tv[2]  = mk(1, {9'h193, 45'd0}, -1, 1, 0, 32'h5, 4'h0, 1, 3'b001, 1);
    tv[3]  = mk(2, {9'h000, 9'h011, 36'd0}, 1, 0, 1, 0, 0, 0, 0, 0);
    tv[4]  = mk(5, {9'h001, 9'h002, 9'h003, 9'h004, 9'h005, 9'h000}, -1, 0, 1, 0, 0, 0, 0, 0);
    tv[5]  = mk(3, {9'h0AA, 9'h0BB, 9'h101, 27'd0}, -1, 0, 1, 0, 0, 0, 0, 0);
    tv[6]  = mk(5, {9'h012, 9'h034, 9'h056, 9'h078, ctl6, 9'h000}, -1, 1, 0, 32'h12345678, 4'b1010, 0, 3'd0, 1);
    tv[7]  = mk(1, {9'h192, 45'd0}, -1, 1, 0, 32'h12345678, 4'b1010, 1, 3'b001, 0);
    tv[8]  = mk(1, {9'h1EE, 45'd0}, -1, 1, 0, 32'h12345678, 4'b1010, 1, 3'b110, 0);
    tv[9]  = mk(1, {9'h1FF, 45'd0}, -1, 1, 0, 32'h12345678, 4'b1010, 1, 3'b111, 1);
    tv[10] = mk(3, {9'h000, 9'h000, 9'h193, 27'd0}, -1, 0, 1, 0, 0, 0, 0, 0);
    tv[11] = mk(1, {9'h101, 45'd0}, -1, 0, 1, 0, 0, 0, 0, 0);
    tv[12] = mk(5, {9'h0DE, 9'h0AD, 9'h0BE, 9'h0EF, ctl12, 9'h000}, -1, 1, 0, 32'hDEADBEEF, 4'b0110, 0, 3'd0, 0);

    reset_n = 1'b0;
    sout    = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    idle(20);
    #2;
    chk("idle valid count", n_valid, 0);
    chk("idle frame_err count", n_fe, 0);
    chk("idle valid", {31'd0, valid}, 0);
    chk("idle frame_err", {31'd0, frame_err}, 0);
    chk("idle err_flags", {29'd0, err_flags}, 0);
    check_held("idle");

    for (int k = 0; k < 13; k++) begin
      v0 = n_valid;
      f0 = n_fe;
      if (k == 0) mark_start = 1'b1;
      for (int j = 0; j < tv[k].nb; j++)
        send_byte(tv[k].b[j][8], tv[k].b[j][7:0], (j == tv[k].bad_stop) ? 1'b0 : 1'b1);
      idle(3);
      #2;
      chk($sformatf("vec%0d valid count", k), n_valid - v0, {31'd0, tv[k].exp_v});
      chk($sformatf("vec%0d frame_err count", k), n_fe - f0, {31'd0, tv[k].exp_fe});
      if (tv[k].exp_v) begin
        m_c = tv[k].exp_c; m_fl = tv[k].exp_fl; m_err = tv[k].exp_err; m_ok = tv[k].exp_ok;
        if (tv[k].exp_err) m_ef = tv[k].exp_ef;
      end
      check_held($sformatf("vec%0d", k));
      // Last stop bit is the 55th sampled bit; valid is seen on the following edge.
      if (k == 0) chk("latency", last_valid_cyc - start_cyc, 54);
    end

    // Timeout: 254 idle cycles is tolerated, the 255th aborts the packet.
    v0 = n_valid;
    f0 = n_fe;
    send_byte(1'b0, 8'h11, 1'b1);
    send_byte(1'b0, 8'h22, 1'b1);
    idle(254);
    @(negedge clk);
    #2;
    chk("timeout early", n_fe - f0, 0);
    @(negedge clk);
    #2;
    chk("timeout fire", n_fe - f0, 1);
    idle(20);
    #2;
    chk("timeout single pulse", n_fe - f0, 1);
    chk("timeout no valid", n_valid - v0, 0);
    check_held("timeout held");
    pkt_q = {9'h0CA, 9'h0FE, 9'h0BA, 9'h0BE, {1'b1, 1'b0, 4'b0011, crc_model({32'hCAFEBABE, 1'b0, 4'b0011})}};
    run_pkt("after timeout", 1'b0);

    // Reset pulse mid-packet: partial bytes are dropped and outputs clear.
    send_byte(1'b0, 8'h77, 1'b1);
    send_byte(1'b0, 8'h66, 1'b1);
    send_byte(1'b0, 8'h55, 1'b1);
    @(negedge clk);
    sout    = 1'b1;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #2;
    m_c = 32'd0; m_fl = 4'd0; m_err = 1'b0; m_ef = 3'd0; m_ok = 1'b0; mbc = 0;
    chk("reset err_flags", {29'd0, err_flags}, 0);
    check_held("after reset");
    pkt_q = {9'h0A1, 9'h0B2, 9'h0C3, 9'h0D4, {1'b1, 1'b0, 4'b1001, crc_model({32'hA1B2C3D4, 1'b0, 4'b1001})}};
    run_pkt("post-reset packet", 1'b0);

    for (int p = 0; p < 40; p++) begin
      int nd;
      logic [3:0] fl;
      logic [2:0] crc, ef;
      logic [7:0] d;
      pkt_q = {};
      nd = ($urandom_range(0, 9) < 6) ? 4 : $urandom_range(0, 5);
      for (int i = 0; i < nd; i++) pkt_q.push_back({1'b0, 8'($urandom)});
      if ($urandom_range(0, 1) == 1) begin
        fl  = 4'($urandom);
        crc = 3'($urandom);
        if (nd == 4) begin
          crc = crc_model({pkt_q[0][7:0], pkt_q[1][7:0], pkt_q[2][7:0], pkt_q[3][7:0], 1'b0, fl});
          if ($urandom_range(0, 3) == 0) crc = crc ^ 3'($urandom_range(1, 7));
        end
        pkt_q.push_back({1'b1, 1'b0, fl, crc});
      end else begin
        ef   = 3'($urandom);
        d    = {1'b1, ef, ef, 1'b0};
        d[0] = ^d[7:1];
        if ($urandom_range(0, 2) == 0) d[$urandom_range(0, 6)] ^= 1'b1;
        pkt_q.push_back({1'b1, d});
      end
      run_pkt($sformatf("rand%0d", p), 1'b1);
    end

    chk("valid and frame_err overlap", n_both, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
